// File: rtl/mlvds_tx_arb_if.sv
// Requester and transmitter signals of mlvds_tx_arb.
// slave is the arbiter's view; master is the requesters'/transmitter's view.
interface mlvds_tx_arb_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [7:0] d0, d1;
    logic       dv0, dv1;
    logic [7:0] txd;
    logic       txdv;
    logic       tx_active;
    logic       busy, ovf, wdog;

    modport slave  (input  req, d0, d1, dv0, dv1, tx_active,
                    output gnt, txd, txdv, busy, ovf, wdog);
    modport master (output req, d0, d1, dv0, dv1, tx_active,
                    input  gnt, txd, txdv, busy, ovf, wdog);
endinterface

// File: rtl/mlvds_tx_arb.sv
// Two-requester round-robin arbiter streaming one packet at a time into an MLVDS transmitter.
// Optional wait-state watchdog: define MLVDS_TX_ARB_WDOG_EN.
module mlvds_tx_arb #(
    parameter logic [8:0]  MAX_LEN     = 9'd511,
    parameter logic [15:0] WDOG_CYCLES = 16'hffff
) (
    input logic           c,
    input logic           rst,
    mlvds_tx_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, GRANT, STREAM, WAIT_TX_START, WAIT_TX_DONE} state_e;

    if (MAX_LEN == 9'd0) begin : g_bad_len
        $error("MAX_LEN must be nonzero");
    end
    if (WDOG_CYCLES == 16'd0) begin : g_bad_wdog
        $error("WDOG_CYCLES must be nonzero");
    end

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] txd_q, txd_d;
    logic       txdv_q, txdv_d;
    logic       ovf_q, ovf_d;
    logic       wdog_q, wdog_d;
    logic [8:0] cnt_q, cnt_d;
    logic       win_q, win_d;
    logic       last_q, last_d;
    logic [1:0] blk_q, blk_d;
    logic       seen_low_q, seen_low_d;
    logic       wdog_hit;

    logic [1:0] dv_eff;
    logic       sel_req, sel_dv;
    logic [7:0] sel_d;

    // A truncated requester's dv stays masked until it drops, so its tail is never taken as a new packet.
    assign dv_eff  = {bus.dv1, bus.dv0} & ~blk_q;
    assign sel_req = bus.req[win_q];
    assign sel_dv  = dv_eff[win_q];
    assign sel_d   = win_q ? bus.d1 : bus.d0;

`ifdef MLVDS_TX_ARB_WDOG_EN
    logic [15:0] wcnt_q, wcnt_d;

    assign wdog_hit = (wcnt_q + 16'd1) == WDOG_CYCLES;

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_d != state_q)
            wcnt_d = '0;
        else if (state_q == WAIT_TX_START || state_q == WAIT_TX_DONE)
            wcnt_d = wcnt_q + 16'd1;
    end

    always_ff @(posedge c) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        txd_d      = '0;
        txdv_d     = 1'b0;
        ovf_d      = 1'b0;
        wdog_d     = 1'b0;
        cnt_d      = cnt_q;
        win_d      = win_q;
        last_d     = last_q;
        blk_d      = blk_q & {bus.dv1, bus.dv0};
        seen_low_d = seen_low_q | ~bus.tx_active;
        unique case (state_q)
            IDLE: begin
                // A tx_active already high here must drop before it can count as a start.
                seen_low_d = ~bus.tx_active;
                if (|bus.req) begin
                    win_d   = (&bus.req) ? ~last_q : bus.req[1];
                    gnt_d   = win_d ? 2'b10 : 2'b01;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (sel_dv) begin
                    txd_d   = sel_d;
                    txdv_d  = 1'b1;
                    cnt_d   = 9'd1;
                    last_d  = win_q;
                    state_d = STREAM;
                end else if (!sel_req) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (!sel_dv) begin
                    gnt_d   = '0;
                    state_d = WAIT_TX_START;
                end else if (cnt_q == MAX_LEN) begin
                    gnt_d        = '0;
                    ovf_d        = 1'b1;
                    blk_d[win_q] = 1'b1;
                    state_d      = WAIT_TX_START;
                end else begin
                    txd_d  = sel_d;
                    txdv_d = 1'b1;
                    cnt_d  = cnt_q + 9'd1;
                end
            end
            WAIT_TX_START: begin
                if (bus.tx_active && seen_low_q) begin
                    state_d = WAIT_TX_DONE;
                end else if (wdog_hit) begin
                    wdog_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_TX_DONE: begin
                if (!bus.tx_active) begin
                    state_d = IDLE;
                end else if (wdog_hit) begin
                    wdog_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            txd_q      <= '0;
            txdv_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wdog_q     <= 1'b0;
            cnt_q      <= '0;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            blk_q      <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            txd_q      <= txd_d;
            txdv_q     <= txdv_d;
            ovf_q      <= ovf_d;
            wdog_q     <= wdog_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            last_q     <= last_d;
            blk_q      <= blk_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.txd  = txd_q;
    assign bus.txdv = txdv_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.ovf  = ovf_q;
    assign bus.wdog = wdog_q;
endmodule

// File: tb/tb_mlvds_tx_arb.sv
// Bench for mlvds_tx_arb: directed vector table, hand-written corner sequences,
// then random packet rounds checked against a packet-level round-robin model.
module tb_mlvds_tx_arb;
    localparam logic [8:0]  MAXL = 9'd4;
    localparam logic [15:0] WDOG = 16'd100;

    logic c = 1'b0;
    logic rst;
    mlvds_tx_arb_if bus ();

    mlvds_tx_arb #(.MAX_LEN(MAXL), .WDOG_CYCLES(WDOG)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 c = ~c;

    int         checks = 0;
    int         failures = 0;
    logic       m_last;
    logic [1:0] pend;

    typedef struct packed {
        logic       r;
        logic [1:0] req;
        logic       dv0;
        logic [7:0] d0;
        logic       dv1;
        logic [7:0] d1;
        logic       tx;
        logic [1:0] gnt;
        logic       txdv;
        logic [7:0] txd;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t v(input int r, input int rq, input int a0, input int b0, input int a1,
                               input int b1, input int tx, input int g, input int dv, input int d,
                               input int bz, input int o);
        vec_t x;
        x.r = 1'(r);     x.req = 2'(rq);  x.dv0 = 1'(a0); x.d0 = 8'(b0);
        x.dv1 = 1'(a1);  x.d1 = 8'(b1);   x.tx = 1'(tx);
        x.gnt = 2'(g);   x.txdv = 1'(dv); x.txd = 8'(d);  x.busy = 1'(bz); x.ovf = 1'(o);
        return x;
    endfunction

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic exp_o(input string tag, input logic [1:0] g, input logic dv, input logic bz, input logic o);
        chk(tag, "gnt",  32'(bus.gnt),  32'(g));
        chk(tag, "txdv", 32'(bus.txdv), 32'(dv));
        chk(tag, "busy", 32'(bus.busy), 32'(bz));
        chk(tag, "ovf",  32'(bus.ovf),  32'(o));
    endtask

    task automatic idle_in();
        bus.req = 2'b00; bus.dv0 = 1'b0; bus.d0 = 8'h00;
        bus.dv1 = 1'b0;  bus.d1 = 8'h00; bus.tx_active = 1'b0;
    endtask

    task automatic garbage(input logic w);
        if (w) begin bus.dv0 = 1'($urandom_range(0, 1)); bus.d0 = 8'($urandom); end
        else   begin bus.dv1 = 1'($urandom_range(0, 1)); bus.d1 = 8'($urandom); end
    endtask

    // One packet-level round: model picks the winner from pending requests and the last grant.
    task automatic rand_round();
        logic       w;
        logic [7:0] b;
        int         len, gap, k, m;
        pend = pend | 2'($urandom_range(1, 3));
        idle_in();
        bus.req = pend;
        w = (pend == 2'b11) ? ~m_last : pend[1];
        step();
        exp_o("rnd.grant", oh(w), 1'b0, 1'b1, 1'b0);
        if ($urandom_range(0, 4) == 0) begin
            bus.req[w] = 1'b0;
            step();
            exp_o("rnd.cancel", 2'b00, 1'b0, 1'b0, 1'b0);
        end else begin
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                garbage(w);
                step();
                exp_o("rnd.gap", oh(w), 1'b0, 1'b1, 1'b0);
            end
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                garbage(w);
                if (w) begin bus.dv1 = 1'b1; bus.d1 = b; end
                else   begin bus.dv0 = 1'b1; bus.d0 = b; end
                step();
                exp_o("rnd.byte", (i < int'(MAXL)) ? oh(w) : 2'b00, i < int'(MAXL), 1'b1, i == int'(MAXL));
                if (i < int'(MAXL)) chk("rnd.byte", "txd", 32'(bus.txd), 32'(b));
            end
            m_last = w;
            bus.dv0 = 1'b0; bus.dv1 = 1'b0;
            bus.req[w] = 1'b0;
            pend[w] = 1'b0;
            step();
            exp_o("rnd.end", 2'b00, 1'b0, 1'b1, 1'b0);
            chk("rnd.end", "wdog", 32'(bus.wdog), 32'd0);
            k = $urandom_range(0, 3);
            m = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                step();
                exp_o("rnd.txwait", 2'b00, 1'b0, 1'b1, 1'b0);
            end
            bus.tx_active = 1'b1;
            for (int i = 0; i < m; i++) begin
                step();
                exp_o("rnd.txhigh", 2'b00, 1'b0, 1'b1, 1'b0);
            end
            bus.tx_active = 1'b0;
            step();
            exp_o("rnd.txdone", 2'b00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ob[6];

        // Reset, 4-byte packet at MAX_LEN, cancel, contention, garbage on the other port, dv-over-req priority.
        vt[0]  = v(1, 0, 0, 0,    0, 0,    0,  0, 0, 0,    0, 0);
        vt[1]  = v(0, 1, 0, 0,    0, 0,    0,  1, 0, 0,    1, 0);
        vt[2]  = v(0, 1, 1, 'h11, 0, 0,    0,  1, 1, 'h11, 1, 0);
        vt[3]  = v(0, 1, 1, 'h22, 0, 0,    0,  1, 1, 'h22, 1, 0);
        vt[4]  = v(0, 1, 1, 'h33, 0, 0,    0,  1, 1, 'h33, 1, 0);
        vt[5]  = v(0, 1, 1, 'h44, 0, 0,    0,  1, 1, 'h44, 1, 0);
        vt[6]  = v(0, 0, 0, 0,    0, 0,    0,  0, 0, 0,    1, 0);
        vt[7]  = v(0, 0, 0, 0,    0, 0,    1,  0, 0, 0,    1, 0);
        vt[8]  = v(0, 0, 0, 0,    0, 0,    1,  0, 0, 0,    1, 0);
        vt[9]  = v(0, 0, 0, 0,    0, 0,    0,  0, 0, 0,    0, 0);
        vt[10] = v(0, 2, 0, 0,    0, 0,    0,  2, 0, 0,    1, 0);
        vt[11] = v(0, 0, 0, 0,    0, 0,    0,  0, 0, 0,    0, 0);
        vt[12] = v(0, 3, 0, 0,    0, 0,    0,  2, 0, 0,    1, 0);
        vt[13] = v(0, 3, 1, 'hFF, 1, 'hA1, 0,  2, 1, 'hA1, 1, 0);
        vt[14] = v(0, 1, 0, 0,    0, 0,    0,  0, 0, 0,    1, 0);
        vt[15] = v(0, 1, 0, 0,    0, 0,    1,  0, 0, 0,    1, 0);
        vt[16] = v(0, 1, 0, 0,    0, 0,    0,  0, 0, 0,    0, 0);
        vt[17] = v(0, 1, 0, 0,    0, 0,    0,  1, 0, 0,    1, 0);
        vt[18] = v(0, 1, 0, 0,    0, 0,    0,  1, 0, 0,    1, 0);
        vt[19] = v(0, 0, 1, 'h5A, 0, 0,    0,  1, 1, 'h5A, 1, 0);
        vt[20] = v(0, 0, 0, 0,    0, 0,    0,  0, 0, 0,    1, 0);
        vt[21] = v(0, 0, 0, 0,    0, 0,    1,  0, 0, 0,    1, 0);
        vt[22] = v(0, 0, 0, 0,    0, 0,    0,  0, 0, 0,    0, 0);

        rst = 1'b1;
        idle_in();
        pend = 2'b00;
        for (int i = 0; i < 23; i++) begin
            rst = vt[i].r;
            bus.req = vt[i].req; bus.dv0 = vt[i].dv0; bus.d0 = vt[i].d0;
            bus.dv1 = vt[i].dv1; bus.d1 = vt[i].d1;   bus.tx_active = vt[i].tx;
            step();
            exp_o($sformatf("vec%0d", i), vt[i].gnt, vt[i].txdv, vt[i].busy, vt[i].ovf);
            if (vt[i].txdv || vt[i].r)
                chk($sformatf("vec%0d", i), "txd", 32'(bus.txd), 32'(vt[i].txd));
            if (vt[i].r)
                chk("vec0", "wdog", 32'(bus.wdog), 32'd0);
        end
        m_last = 1'b0;

        // Overlength: 6 bytes with MAX_LEN=4, then the stale dv tail must not start a new packet.
        ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        idle_in();
        bus.req = 2'b01;
        step();
        exp_o("ovl.grant", 2'b01, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.dv0 = 1'b1; bus.d0 = ob[i];
            step();
            exp_o($sformatf("ovl.b%0d", i), (i < 4) ? 2'b01 : 2'b00, i < 4, 1'b1, i == 4);
            if (i < 4) chk($sformatf("ovl.b%0d", i), "txd", 32'(bus.txd), 32'(ob[i]));
            else       chk($sformatf("ovl.b%0d", i), "txd_not_fwd", 32'(bus.txd == ob[i]), 32'd0);
        end
        bus.tx_active = 1'b1;
        step();
        exp_o("ovl.txhigh", 2'b00, 1'b0, 1'b1, 1'b0);
        bus.tx_active = 1'b0;
        step();
        exp_o("ovl.idle", 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        exp_o("ovl.regrant", 2'b01, 1'b0, 1'b1, 1'b0);
        step();
        exp_o("ovl.stale_dv", 2'b01, 1'b0, 1'b1, 1'b0);
        bus.dv0 = 1'b0;
        step();
        exp_o("ovl.dv_low", 2'b01, 1'b0, 1'b1, 1'b0);
        bus.dv0 = 1'b1; bus.d0 = 8'h77;
        step();
        exp_o("ovl.new", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("ovl.new", "txd", 32'(bus.txd), 32'h77);
        bus.dv0 = 1'b0; bus.req = 2'b00;
        step();
        bus.tx_active = 1'b1;
        step();
        bus.tx_active = 1'b0;
        step();
        exp_o("ovl.done", 2'b00, 1'b0, 1'b0, 1'b0);

        // tx_active high since IDLE is not a start; it must fall and rise again.
        bus.tx_active = 1'b1; bus.req = 2'b01;
        step();
        exp_o("stale.grant", 2'b01, 1'b0, 1'b1, 1'b0);
        bus.dv0 = 1'b1; bus.d0 = 8'h3C;
        step();
        chk("stale.byte", "txd", 32'(bus.txd), 32'h3C);
        bus.dv0 = 1'b0; bus.req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_o("stale.held", 2'b00, 1'b0, 1'b1, 1'b0);
        end
        bus.tx_active = 1'b0;
        step();
        exp_o("stale.fall", 2'b00, 1'b0, 1'b1, 1'b0);
        bus.tx_active = 1'b1;
        step();
        exp_o("stale.start", 2'b00, 1'b0, 1'b1, 1'b0);
        bus.tx_active = 1'b0;
        step();
        exp_o("stale.done", 2'b00, 1'b0, 1'b0, 1'b0);

        // Transmitter never starts after a packet.
        bus.req = 2'b01;
        step();
        bus.dv0 = 1'b1; bus.d0 = 8'hC3;
        step();
        bus.dv0 = 1'b0; bus.req = 2'b00;
        step();
        exp_o("wd.enter", 2'b00, 1'b0, 1'b1, 1'b0);
`ifdef MLVDS_TX_ARB_WDOG_EN
        for (int j = 1; j <= int'(WDOG); j++) begin
            step();
            chk($sformatf("wd.c%0d", j), "wdog", 32'(bus.wdog), 32'(j == int'(WDOG)));
            chk($sformatf("wd.c%0d", j), "busy", 32'(bus.busy), 32'(j != int'(WDOG)));
        end
        step();
        chk("wd.after", "wdog", 32'(bus.wdog), 32'd0);
`else
        for (int j = 1; j <= 150; j++) begin
            step();
            chk($sformatf("wd.c%0d", j), "busy", 32'(bus.busy), 32'd1);
            chk($sformatf("wd.c%0d", j), "wdog", 32'(bus.wdog), 32'd0);
        end
        bus.tx_active = 1'b1;
        step();
        bus.tx_active = 1'b0;
        step();
        exp_o("wd.done", 2'b00, 1'b0, 1'b0, 1'b0);
`endif

        // Reset on the 3rd byte of a contended packet; requester 0 must win first afterwards.
        bus.req = 2'b11;
        step();
        exp_o("rst.grant", oh(~m_last), 1'b0, 1'b1, 1'b0);
        bus.dv1 = 1'b1; bus.d1 = 8'hB1;
        step();
        bus.d1 = 8'hB2;
        step();
        exp_o("rst.b2", 2'b10, 1'b1, 1'b1, 1'b0);
        bus.d1 = 8'hB3; rst = 1'b1;
        step();
        exp_o("rst.hit", 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; bus.dv1 = 1'b0;
        m_last = 1'b1;
        step();
        exp_o("rst.first", 2'b01, 1'b0, 1'b1, 1'b0);
        bus.req = 2'b00;
        step();
        exp_o("rst.cancel", 2'b00, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 80; r++) rand_round();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mlvds_tx_arb.md
MLVDS_TX_ARB -- requirements
Module: mlvds_tx_arb

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 9'd511, giving the maximum number of frame bytes forwarded per packet (the TX FIFO holds 512 bytes).
REQ-002 The block SHALL have parameter WDOG_CYCLES, default 16'hffff, giving the watchdog limit in clock cycles.
REQ-003 c  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req  in  2  per-requester packet request; bit n belongs to requester n.
REQ-006 gnt  out  2  one-hot grant, registered.
REQ-007 d0, d1  in  8 each  frame byte from requester 0 / requester 1.
REQ-008 dv0, dv1  in  1 each  byte valid from requester 0 / requester 1; contiguous for the whole packet.
REQ-009 txd  out  8  byte to the MLVDS transmitter, registered.
REQ-010 txdv  out  1  byte valid to the MLVDS transmitter; its falling edge ends the packet.
REQ-011 tx_active  in  1  MLVDS transmitter driving the line.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 ovf  out  1  one-cycle pulse when a packet is truncated at MAX_LEN.
REQ-014 wdog  out  1  one-cycle pulse on watchdog abort; tied to 0 when the watchdog is compiled out.

Function
REQ-015 The state machine SHALL have the states IDLE, GRANT, STREAM, WAIT_TX_START and WAIT_TX_DONE.
REQ-016 IDLE: if any req bit is high, the block SHALL select a winner by round-robin, go to GRANT and assert gnt for the winner on the next cycle.
REQ-017 Round-robin: when both req bits are high, the winner SHALL be the requester that was not granted last; when only one req bit is high, that requester SHALL win.
REQ-018 The last-granted pointer SHALL update only on GRANT->STREAM; a cancelled grant SHALL leave it unchanged.
REQ-019 GRANT: when the granted dv is high, the block SHALL go to STREAM; when the granted req drops before dv, the block SHALL go to IDLE, drop gnt and emit no txdv.
REQ-020 STREAM: each granted byte with dv high SHALL appear on txd with txdv high exactly 1 cycle later; the ungranted requester's d/dv SHALL be ignored at all times.
REQ-021 A 9-bit byte counter SHALL clear on entry to STREAM and increment on each forwarded byte.
REQ-022 When the granted dv falls in STREAM, txdv SHALL be low on the next cycle and the block SHALL go to WAIT_TX_START, with gnt deasserted in the same cycle.
REQ-023 When the byte counter reaches MAX_LEN, further bytes SHALL NOT be forwarded, txdv SHALL fall, ovf SHALL pulse once, gnt SHALL deassert and the block SHALL go to WAIT_TX_START.
REQ-024 After truncation, dv from the truncated requester SHALL be ignored until that dv goes low.
REQ-025 WAIT_TX_START: tx_active high SHALL move the block to WAIT_TX_DONE; a tx_active held high since IDLE SHALL NOT count as a new start.
REQ-026 WAIT_TX_DONE: tx_active low SHALL move the block to IDLE; no new grant SHALL be issued in the same cycle.
REQ-027 When req and dv both change on one edge in GRANT, dv SHALL take priority and the block SHALL go to STREAM.

Reset
REQ-028 rst SHALL force: state=IDLE, gnt=0, txd=0, txdv=0, busy=0, ovf=0, wdog=0, byte counter=0, watchdog counter=0, last-granted pointer=1 (so requester 0 wins first).
REQ-029 rst during STREAM SHALL drop txdv on the next cycle; recovery of the partial packet already handed to the transmitter is outside this block.

Configuration
REQ-030 With MLVDS_TX_ARB_WDOG_EN defined, a 16-bit counter SHALL clear on entry to WAIT_TX_START and on entry to WAIT_TX_DONE, and increment each cycle in those states.
REQ-031 With MLVDS_TX_ARB_WDOG_EN defined, when that counter reaches WDOG_CYCLES the block SHALL pulse wdog and go to IDLE.
REQ-032 Without MLVDS_TX_ARB_WDOG_EN, the counter SHALL be absent, wdog SHALL be constant 0 and both wait states SHALL wait indefinitely.

Verification
REQ-033 Single packet: req0=1; dv0 high for 4 bytes 0x11,0x22,0x33,0x44 -> txd carries the same bytes, each 1 cycle after input; txdv falls 1 cycle after dv0 falls; busy stays high until tx_active completes a high-low cycle.
REQ-034 Contention: req0=req1=1 held high for three packets -> grant order 0,1,0; no grant is issued while tx_active is high.
REQ-035 Overlength: MAX_LEN=4, 6-byte burst -> exactly 4 bytes forwarded, ovf pulses once, bytes 5-6 are never on txd.
REQ-036 Cancel: req1 pulses high for 1 cycle with no dv1 -> gnt1 pulses, block returns to IDLE, txdv stays 0, next contention grants requester 1.
REQ-037 Watchdog (MLVDS_TX_ARB_WDOG_EN, WDOG_CYCLES=100): tx_active held low after a packet -> wdog pulses 100 cycles after entering WAIT_TX_START, block returns to IDLE; with the macro undefined, the block stays in WAIT_TX_START.
REQ-038 Reset mid-stream: rst asserted on the 3rd byte -> txdv=0 and gnt=0 the next cycle; first grant after reset goes to requester 0 with both req high.
